// File: rtl/tv_b_gone_pkg.sv
// Shared types and default timing constants for the tv_b_gone front-end logic.
package tv_b_gone_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DOWN,
        LONG
    } trig_state_t;

    localparam int DEBOUNCE_CYCLES_DEF = 80000;     // 10 ms at 8 MHz
    localparam int LONG_CYCLES_DEF     = 16000000;  // 2 s at 8 MHz

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchroniser plus hold-time debouncer for an asynchronous button pin.
// stable_out follows the pin polarity (low = pressed) and resets released.
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 80000
) (
    input  logic clock_in,
    input  logic resetn_in,
    input  logic raw_n_in,
    output logic stable_out
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_a;
    logic             sync_b;
    logic [CNT_W-1:0] cnt;

    // Any sample agreeing with the stable level restarts the hold window.
    always_ff @(posedge clock_in or negedge resetn_in) begin
        if (!resetn_in) begin
            sync_a     <= 1'b1;
            sync_b     <= 1'b1;
            stable_out <= 1'b1;
            cnt        <= '0;
        end else begin
            sync_a <= raw_n_in;
            sync_b <= sync_a;
            if (sync_b == stable_out) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                stable_out <= sync_b;
                cnt        <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/start_trigger.sv
// Turns the raw push-button into a one-cycle start pulse for tv_b_gone, gated by busy.
// START_TRIGGER_LONG_PRESS_EN: start on short release, long hold toggles loop mode.
module start_trigger
    import tv_b_gone_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int LONG_CYCLES     = LONG_CYCLES_DEF
) (
    input  logic clock_in,
    input  logic resetn_in,
    input  logic button_n_in,
    input  logic busy_in,
    output logic start_out,
    output logic pressed_out,
    output logic loop_forever_out
);

    trig_state_t state;
    logic        stable_n;

    button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clock_in  (clock_in),
        .resetn_in (resetn_in),
        .raw_n_in  (button_n_in),
        .stable_out(stable_n)
    );

    assign pressed_out = ~stable_n;

`ifdef START_TRIGGER_LONG_PRESS_EN
    localparam int HOLD_W = (LONG_CYCLES > 1) ? $clog2(LONG_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);

    logic [HOLD_W-1:0] hold_cnt;

    // The press is classified only on release or once the hold limit is hit.
    always_ff @(posedge clock_in or negedge resetn_in) begin
        if (!resetn_in) begin
            state            <= IDLE;
            start_out        <= 1'b0;
            loop_forever_out <= 1'b0;
            hold_cnt         <= '0;
        end else begin
            start_out <= 1'b0;
            case (state)
                IDLE: begin
                    hold_cnt <= '0;
                    if (pressed_out) state <= DOWN;
                end
                DOWN: begin
                    if (!pressed_out) begin
                        start_out <= ~busy_in;
                        state     <= IDLE;
                    end else if (hold_cnt == HOLD_LAST) begin
                        loop_forever_out <= ~loop_forever_out;
                        state            <= LONG;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                LONG: begin
                    if (!pressed_out) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
`else
    logic unused_long;
    assign unused_long      = ^LONG_CYCLES;
    assign loop_forever_out = 1'b0;

    always_ff @(posedge clock_in or negedge resetn_in) begin
        if (!resetn_in) begin
            state     <= IDLE;
            start_out <= 1'b0;
        end else begin
            start_out <= 1'b0;
            case (state)
                IDLE: begin
                    if (pressed_out) begin
                        start_out <= ~busy_in;
                        state     <= DOWN;
                    end
                end
                DOWN: begin
                    if (!pressed_out) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
`endif

endmodule
